shared_sat_mult_sched: RTL and testbench
========================================

Name: shared_sat_mult_sched

Overview:
- Round-robin scheduler that time-shares one pipelined saturating fixed-point multiplier among NREQ requesters, such as PI/PR controller channels in the FPGA control path.
- Each accepted request carries a requester tag through a 3-stage pipeline.
- The result is broadcast with that tag, a saturated product and an overflow flag.
- Throughput: one multiply per clock.

Parameters:
- NREQ, 4, number of requesters (>= 2); IDW = $clog2(NREQ) is a localparam.
- N, 16, signed operand width.
- FRAC, 15, arithmetic right shift applied to the 2N-bit product (Q-format alignment).
- M, 16, signed result width; M + FRAC <= 2N, checked at elaboration.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable; low = no new grants, pipeline keeps draining.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant (one-hot or zero).
- req_x  in  NREQ*N  packed operand x; slice i belongs to requester i.
- req_y  in  NREQ*N  packed operand y.
- rsp_valid  out  1  result valid, single-cycle pulse per result.
- rsp_id  out  IDW  requester index of the result.
- rsp_z  out  M  saturated result.
- rsp_ov  out  1  overflow/saturation occurred.
- busy  out  1  any pipeline stage holds a valid entry.

Behaviour:
- Reset (async, rst_n=0): all stage valids=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_ov=0, busy=0, RR pointer = NREQ-1 (requester 0 wins first). Reset mid-operation discards all in-flight entries; no response is ever emitted for them.
- Arbitration (combinational):
  - Search req_valid starting at pointer+1 mod NREQ; the first set bit wins.
  - req_ready = en ? onehot(winner) : 0.
  - Handshake fires when req_valid[i] & req_ready[i] at a clock edge.
  - On accept, pointer <= winner; otherwise the pointer holds.
  - req_ready never depends on downstream state: the response path has no backpressure.
- Requester rules:
  - Requester must hold req_valid and its operands stable until accepted.
  - Dropping req_valid before accept is allowed; no grant results.
- Pipeline (accepting edge = E0):
  - S1 at E0: register x, y, id, valid.
  - S2 at E0+1: full-precision signed product P = x*y (2N bits), registered.
  - S3 at E0+2: saturation and output registers.
  - rsp_valid is high in the cycle after E0+2, i.e. latency is exactly 3 edges.
  - Back-to-back accepts yield back-to-back responses in acceptance order.
- Arithmetic:
  - Q = P >>> FRAC (arithmetic, floor toward -inf, no rounding).
  - ov = 1 iff bits Q[2N-1-FRAC : M-1] are not all equal.
  - If ov=0: z = Q[M-1:0].
  - If ov=1: z = 0 followed by ones (max positive) when P[2N-1]=0; z = 1 followed by zeros (min negative) when P[2N-1]=1.
- en low mid-stream: in-flight entries complete normally; busy falls the cycle after the last rsp_valid.
- Simultaneous requests: exactly one grant per cycle. All NREQ continuously valid gives strict rotation 0,1,..,NREQ-1,0.
- Single active requester: granted every cycle (pointer wrap allows self-repeat).

Optional Feature:
- Macro SHARED_SAT_MULT_OV_CNT_EN. When defined, add two ports:
  - ov_cnt_clr  in  1  synchronous clear of all counters.
  - ov_cnt  out  NREQ*16  per-requester overflow counters.
- Counter rsp_id increments when rsp_valid & rsp_ov, saturating at 16'hFFFF.
- If clear and increment coincide, the counter becomes 0.
- Counters reset to 0 on rst_n.
- Without the macro: no counter ports or logic; all other behaviour is identical.

Decomposition:
- Package gmp_math_pkg holds:
  - the saturation helper: max/min constants built from M;
  - the IDW clog2 function;
  - the default Q15 constants N=16, FRAC=15, M=16.
- Natural sub-module: sat_mult_pipe, covering stages S1-S3 with a tag sideband and no arbitration.
- The top level holds the RR arbiter, the pointer and the optional counters.

Test Plan:
- Q15 normal (N=16, FRAC=15, M=16), requester 2 alone: x=16'h4000, y=16'h4000 -> 3 edges after accept: rsp_valid=1, rsp_id=2, rsp_z=16'h2000, rsp_ov=0.
- Positive saturation: x=16'h8000, y=16'h8000 -> rsp_z=16'h7FFF, rsp_ov=1. Negative exact: x=16'h8000, y=16'h7FFF -> rsp_z=16'h8001, rsp_ov=0.
- Round-robin: all 4 req_valid held high for 8 cycles -> req_ready sequence 0,1,2,3,0,1,2,3; rsp_id in the same order with no gaps, starting 3 cycles later.
- en deasserted with 2 entries in flight -> no new req_ready, 2 more rsp_valid pulses, then busy=0. Re-asserting en resumes from pointer+1.
- rst_n pulsed low while 3 entries are in flight -> all outputs 0 immediately; no rsp_valid after release. The first grant after release goes to requester 0 when all are valid.
- With SHARED_SAT_MULT_OV_CNT_EN: 3 overflowing multiplies from requester 1 -> ov_cnt slice 1 = 3. ov_cnt_clr pulse -> 0. A counter preloaded by 65535 overflows stays at 16'hFFFF.

Source files
------------

// File: rtl/gmp_math_pkg.sv
// rtl/gmp_math_pkg.sv - shared fixed-point math constants and helpers
// Purpose: default Q15 operand/result geometry, requester-index width function,
//          and saturation bound builders used by the shared multiplier.
// Ports:   none (package).
package gmp_math_pkg;

  localparam int Q15_N    = 16;
  localparam int Q15_FRAC = 15;
  localparam int Q15_M    = 16;

  localparam int OV_CNT_W = 16;

  // Width of a requester index; never below one bit.
  function automatic int clog2_id(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  // Largest positive value of an m-bit signed result, in the low m bits.
  function automatic logic [63:0] sat_max(input int m);
    return (64'd1 << (m - 1)) - 64'd1;
  endfunction

  // Most negative value of an m-bit signed result, in the low m bits.
  function automatic logic [63:0] sat_min(input int m);
    return ~sat_max(m);
  endfunction

endpackage

// File: rtl/sat_mult_pipe.sv
// rtl/sat_mult_pipe.sv - three-stage signed saturating multiplier with tag sideband
// Purpose: S1 registers operands and tag, S2 forms the full 2N-bit product,
//          S3 shifts by FRAC, saturates to M bits and registers the result.
// Ports:   clk, rst_n          clock, async active-low reset
//          in_valid/in_id      accepted entry and its requester tag
//          in_x, in_y          signed N-bit operands
//          out_valid/out_id    result strobe and tag
//          out_z, out_ov       saturated result and overflow flag
//          busy                any stage holds a valid entry
module sat_mult_pipe
  import gmp_math_pkg::*;
#(
  parameter int N    = Q15_N,
  parameter int FRAC = Q15_FRAC,
  parameter int M    = Q15_M,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [IDW-1:0] in_id,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic [M-1:0]   out_z,
  output logic           out_ov,
  output logic           busy
);

  if (M + FRAC > 2 * N) begin : g_cfg_check
    $error("sat_mult_pipe: M + FRAC must not exceed 2*N");
  end

  // Bits Q[2N-1-FRAC : M-1] must all agree for the shifted product to fit.
  localparam int UW = 2 * N - FRAC - M + 1;

  localparam logic [63:0] ZMAX_W = sat_max(M);
  localparam logic [63:0] ZMIN_W = sat_min(M);
  localparam logic [M-1:0] ZMAX  = ZMAX_W[M-1:0];
  localparam logic [M-1:0] ZMIN  = ZMIN_W[M-1:0];

  logic           s1_valid;
  logic [IDW-1:0] s1_id;
  logic [N-1:0]   s1_x;
  logic [N-1:0]   s1_y;

  logic           s2_valid;
  logic [IDW-1:0] s2_id;
  logic [2*N-1:0] s2_p;

  logic [2*N-1:0] x_ext;
  logic [2*N-1:0] y_ext;
  logic [2*N-1-FRAC:0] q_keep;
  logic [UW-1:0]  q_top;
  logic           sat_ov;
  logic [M-1:0]   sat_z;

  // Sign-extend so the 2N-bit two's-complement product is exact.
  assign x_ext = {{N{s1_x[N-1]}}, s1_x};
  assign y_ext = {{N{s1_y[N-1]}}, s1_y};

  // Arithmetic shift by FRAC is just dropping the low FRAC product bits.
  assign q_keep = s2_p[2*N-1:FRAC];
  assign q_top  = q_keep[2*N-1-FRAC -: UW];

  if (FRAC > 0) begin : g_drop_lo
    logic unused_p_lo;
    assign unused_p_lo = ^s2_p[FRAC-1:0];
  end

  always_comb begin
    sat_ov = ~((&q_top) | ~(|q_top));
    sat_z  = q_keep[M-1:0];
    if (sat_ov) begin
      sat_z = s2_p[2*N-1] ? ZMIN : ZMAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      s2_p      <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_z     <= '0;
      out_ov    <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_id     <= in_id;
      s1_x      <= in_x;
      s1_y      <= in_y;
      s2_valid  <= s1_valid;
      s2_id     <= s1_id;
      s2_p      <= x_ext * y_ext;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_id <= s2_id;
        out_z  <= sat_z;
        out_ov <= sat_ov;
      end
    end
  end

  assign busy = s1_valid | s2_valid | out_valid;

endmodule

// File: rtl/shared_sat_mult_sched.sv
// rtl/shared_sat_mult_sched.sv - round-robin scheduler sharing one saturating multiplier
// Purpose: grants at most one requester per cycle (rotating priority), feeds the
//          winner into sat_mult_pipe and broadcasts tagged results three edges later.
//          Optional per-requester overflow counters: SHARED_SAT_MULT_OV_CNT_EN.
// Ports:   clk, rst_n            clock, async active-low reset
//          en                    allow new grants (pipeline drains regardless)
//          req_valid/req_ready   per-requester request and one-hot grant
//          req_x, req_y          packed operands, slice i for requester i
//          rsp_valid/rsp_id      result pulse and requester tag
//          rsp_z, rsp_ov         saturated result and overflow flag
//          busy                  pipeline non-empty
//          ov_cnt_clr, ov_cnt    counter clear and packed 16-bit counters (optional)
module shared_sat_mult_sched
  import gmp_math_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int N    = Q15_N,
  parameter  int FRAC = Q15_FRAC,
  parameter  int M    = Q15_M,
  localparam int IDW  = clog2_id(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_x,
  input  logic [NREQ*N-1:0] req_y,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [M-1:0]      rsp_z,
  output logic              rsp_ov,
`ifdef SHARED_SAT_MULT_OV_CNT_EN
  input  logic                     ov_cnt_clr,
  output logic [NREQ*OV_CNT_W-1:0] ov_cnt,
`endif
  output logic              busy
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic           accept;
  logic [N-1:0]   sel_x;
  logic [N-1:0]   sel_y;

  // Rotating priority: the requester just after the last winner is checked first,
  // so a lone requester wraps back to itself and is granted every cycle.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept    = en & found;
  assign req_ready = accept ? (NREQ'(1) << win) : '0;
  assign sel_x     = req_x[int'(win)*N +: N];
  assign sel_y     = req_y[int'(win)*N +: N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDW'(NREQ - 1);
    end else if (accept) begin
      ptr <= win;
    end
  end

  sat_mult_pipe #(
    .N    (N),
    .FRAC (FRAC),
    .M    (M),
    .IDW  (IDW)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_id     (win),
    .in_x      (sel_x),
    .in_y      (sel_y),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_z     (rsp_z),
    .out_ov    (rsp_ov),
    .busy      (busy)
  );

`ifdef SHARED_SAT_MULT_OV_CNT_EN
  // Clear wins over a coincident increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ov_cnt_clr) begin
          ov_cnt[i*OV_CNT_W +: OV_CNT_W] <= '0;
        end else if (rsp_valid && rsp_ov && (rsp_id == IDW'(i)) &&
                     (ov_cnt[i*OV_CNT_W +: OV_CNT_W] != {OV_CNT_W{1'b1}})) begin
          ov_cnt[i*OV_CNT_W +: OV_CNT_W] <= ov_cnt[i*OV_CNT_W +: OV_CNT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_shared_sat_mult_sched.sv
// tb/tb_shared_sat_mult_sched.sv - self-checking bench for shared_sat_mult_sched
module tb_shared_sat_mult_sched;

  localparam int NREQ = 4;
  localparam int N    = 16;
  localparam int FRAC = 15;
  localparam int M    = 16;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_x;
  logic [NREQ*N-1:0] req_y;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [M-1:0]      rsp_z;
  logic              rsp_ov;
  logic              busy;
`ifdef SHARED_SAT_MULT_OV_CNT_EN
  logic              ov_cnt_clr;
  logic [NREQ*16-1:0] ov_cnt;
`endif

  shared_sat_mult_sched #(
    .NREQ (NREQ),
    .N    (N),
    .FRAC (FRAC),
    .M    (M)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .rsp_ov    (rsp_ov),
`ifdef SHARED_SAT_MULT_OV_CNT_EN
    .ov_cnt_clr (ov_cnt_clr),
    .ov_cnt     (ov_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    int          id;
    logic [15:0] z;
    bit          ov;
  } rsp_t;

  rsp_t        pipe [3];
  int          rr;
  int          tests;
  int          fails;
  int          last_win;
  int          grant_log [$];
  bit          pend [NREQ];
  logic [15:0] xs [NREQ];
  logic [15:0] ys [NREQ];
  int          ov_model [NREQ];

  // Reference: exact product, floor shift, clamp to the signed 16-bit range.
  function automatic void ref_mult(input logic [15:0] x, input logic [15:0] y,
                                   output logic [15:0] z, output bit ov);
    longint p;
    longint q;
    p = longint'($signed(x)) * longint'($signed(y));
    q = p >>> FRAC;
    if (q > 32767) begin
      z = 16'h7FFF; ov = 1'b1;
    end else if (q < -32768) begin
      z = 16'h8000; ov = 1'b1;
    end else begin
      z = q[15:0]; ov = 1'b0;
    end
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend[i];
      req_x[i*N +: N]    = xs[i];
      req_y[i*N +: N]    = ys[i];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, id: 0, z: 16'h0, ov: 1'b0};
    rr = NREQ - 1;
  endtask

  // One clock: check grant, advance model across the edge, check outputs.
  task automatic tick();
    int            w;
    logic [NREQ-1:0] er;
    rsp_t          ne;
    apply();
    #1;
    w = -1;
    if (en) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && pend[(rr + k) % NREQ]) w = (rr + k) % NREQ;
      end
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    ne = '{v: 1'b0, id: 0, z: 16'h0, ov: 1'b0};
    last_win = w;
    if (w >= 0) begin
      ne.v  = 1'b1;
      ne.id = w;
      ref_mult(xs[w], ys[w], ne.z, ne.ov);
      rr = w;
      grant_log.push_back(w);
    end
`ifdef SHARED_SAT_MULT_OV_CNT_EN
    for (int i = 0; i < NREQ; i++) begin
      if (ov_cnt_clr) ov_model[i] = 0;
      else if (pipe[2].v && pipe[2].ov && pipe[2].id == i && ov_model[i] < 65535) ov_model[i]++;
    end
`endif
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = ne;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, pipe[2].v);
    chk("busy", busy, pipe[0].v | pipe[1].v | pipe[2].v);
    if (pipe[2].v) begin
      chk("rsp_id", rsp_id, pipe[2].id);
      chk("rsp_z", rsp_z, pipe[2].z);
      chk("rsp_ov", rsp_ov, pipe[2].ov);
    end
`ifdef SHARED_SAT_MULT_OV_CNT_EN
    for (int i = 0; i < NREQ; i++) chk("ov_cnt", ov_cnt[i*16 +: 16], ov_model[i]);
`endif
  endtask

  task automatic single(input int id, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] ez, input bit eov);
    pend[id] = 1'b1; xs[id] = x; ys[id] = y;
    tick();
    pend[id] = 1'b0;
    tick();
    tick();
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_id", rsp_id, id);
    chk("single_z", rsp_z, ez);
    chk("single_ov", rsp_ov, eov);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_z"}, rsp_z, 0);
    chk({tag, "_rsp_ov"}, rsp_ov, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int pulses;
    tests = 0;
    fails = 0;
    last_win = -1;
    rst_n = 1'b0;
    en = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; xs[i] = 16'h0; ys[i] = 16'h0; ov_model[i] = 0;
    end
`ifdef SHARED_SAT_MULT_OV_CNT_EN
    ov_cnt_clr = 1'b0;
`endif
    clear_model();
    apply();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Q15 0.5 * 0.5 from requester 2 alone
    single(2, 16'h4000, 16'h4000, 16'h2000, 1'b0);
    // -1 * -1 saturates; -1 * (1-2^-15) is exact
    single(0, 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    single(0, 16'h8000, 16'h7FFF, 16'h8001, 1'b0);

    // en low with two entries in flight
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1; xs[i] = rnd_op(); ys[i] = rnd_op();
    end
    tick();
    tick();
    en = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick();
      if (rsp_valid) pulses++;
    end
    chk("en_low_pulses", pulses, 2);
    chk("en_low_busy", busy, 1'b0);
    en = 1'b1;
    apply();
    #1;
    chk("en_resume_grant", req_ready, 4'b1000);
    tick();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    repeat (4) tick();

    // Reset with three in flight, then strict rotation from requester 0
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1; xs[i] = rnd_op(); ys[i] = rnd_op();
    end
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) chk("rr_order", grant_log[i], i % NREQ);
      else chk("rr_count", grant_log.size(), 8);
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    repeat (4) tick();

    // Randomized traffic with drops and en toggling
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1; xs[i] = rnd_op(); ys[i] = rnd_op();
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      en = ($urandom_range(0, 7) != 0);
      tick();
      if (last_win >= 0) pend[last_win] = 1'b0;
    end
    en = 1'b1;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    repeat (4) tick();
    chk("drain_busy", busy, 1'b0);

`ifdef SHARED_SAT_MULT_OV_CNT_EN
    ov_cnt_clr = 1'b1;
    tick();
    ov_cnt_clr = 1'b0;
    pend[1] = 1'b1; xs[1] = 16'h8000; ys[1] = 16'h8000;
    repeat (3) tick();
    pend[1] = 1'b0;
    repeat (4) tick();
    chk("ov_cnt_three", ov_cnt[31:16], 16'd3);
    ov_cnt_clr = 1'b1;
    tick();
    ov_cnt_clr = 1'b0;
    chk("ov_cnt_cleared", ov_cnt[31:16], 16'd0);
    pend[1] = 1'b1;
    repeat (65540) tick();
    pend[1] = 1'b0;
    repeat (4) tick();
    chk("ov_cnt_sat", ov_cnt[31:16], 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
